// File: rtl/dbg_dmi_pkg.sv
// Shared DMI definitions: op/response encodings, request/response field
// offsets and the DMI-to-ICB bridge state encoding.
package dbg_dmi_pkg;

    // Field offsets inside the packed DMI request/response vectors
    localparam int unsigned DMI_OP_BITS   = 2;
    localparam int unsigned DMI_DATA_BITS = 32;
    localparam int unsigned REQ_OP_LSB    = 0;
    localparam int unsigned REQ_DATA_LSB  = DMI_OP_BITS;
    localparam int unsigned REQ_ADDR_LSB  = DMI_OP_BITS + DMI_DATA_BITS;
    localparam int unsigned RESP_CODE_LSB = 0;
    localparam int unsigned RESP_DATA_LSB = DMI_OP_BITS;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'b00,
        DMI_OP_READ  = 2'b01,
        DMI_OP_WRITE = 2'b10,
        DMI_OP_RSVD  = 2'b11
    } dmi_op_e;

    // BUSY is never produced here; kept for encoding compatibility
    typedef enum logic [1:0] {
        DMI_RESP_OK   = 2'b00,
        DMI_RESP_ERR  = 2'b10,
        DMI_RESP_BUSY = 2'b11
    } dmi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_RESP = 2'd3
    } b2i_state_e;

endpackage

// File: rtl/debug_bus2icb.sv
// DMI target that turns each DMI request into one ICB transaction.
// Ports:
//   clk, rst                     clock, async active-high reset
//   dtm_req_*                    DMI request channel (op/data/addr packed)
//   dtm_resp_*                   DMI response channel (code/data packed)
//   icb_cmd_*, icb_rsp_*         ICB initiator command/response channels
//   dmi_active                   FSM busy indicator
//   icb_err_cnt                  saturating count of ICB error responses
module debug_bus2icb
    import dbg_dmi_pkg::*;
#(
    parameter int unsigned DEBUG_DATA_BITS = 32,
    parameter int unsigned DEBUG_ADDR_BITS = 7,
    parameter int unsigned DEBUG_OP_BITS   = 2,
    parameter int unsigned DBUS_REQ_BITS   = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
    parameter int unsigned DBUS_RESP_BITS  = DEBUG_OP_BITS + DEBUG_DATA_BITS,
    parameter logic [31:0] ICB_BASE_ADDR   = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dtm_req_valid,
    output logic                        dtm_req_ready,
    input  logic [DBUS_REQ_BITS-1:0]    dtm_req_bits,
    output logic                        dtm_resp_valid,
    input  logic                        dtm_resp_ready,
    output logic [DBUS_RESP_BITS-1:0]   dtm_resp_bits,
    output logic                        icb_cmd_valid,
    input  logic                        icb_cmd_ready,
    output logic [31:0]                 icb_cmd_addr,
    output logic                        icb_cmd_read,
    output logic [31:0]                 icb_cmd_wdata,
    output logic [3:0]                  icb_cmd_wmask,
    input  logic                        icb_rsp_valid,
    output logic                        icb_rsp_ready,
    input  logic [31:0]                 icb_rsp_rdata,
    input  logic                        icb_rsp_err,
    output logic                        dmi_active,
    output logic [7:0]                  icb_err_cnt
);

    // Request field slices
    logic [DEBUG_OP_BITS-1:0]   req_op;
    logic [DEBUG_DATA_BITS-1:0] req_data;
    logic [DEBUG_ADDR_BITS-1:0] req_addr;

    assign req_op   = dtm_req_bits[REQ_OP_LSB   +: DEBUG_OP_BITS];
    assign req_data = dtm_req_bits[REQ_DATA_LSB +: DEBUG_DATA_BITS];
    assign req_addr = dtm_req_bits[REQ_ADDR_LSB +: DEBUG_ADDR_BITS];

    b2i_state_e                 state_q;
    logic [31:0]                cmd_addr_q;
    logic                       cmd_read_q;
    logic [DEBUG_DATA_BITS-1:0] cmd_wdata_q;
    dmi_resp_e                  resp_code_q;
    logic [DEBUG_DATA_BITS-1:0] resp_data_q;
    logic [7:0]                 err_cnt_q;

    // FSM plus command/response capture; fields only change on state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_addr_q  <= '0;
            cmd_read_q  <= 1'b0;
            cmd_wdata_q <= '0;
            resp_code_q <= DMI_RESP_OK;
            resp_data_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dtm_req_valid) begin
                        // Word-indexed DMI address becomes a byte offset, wrapping mod 2^32
                        cmd_addr_q  <= ICB_BASE_ADDR + 32'({req_addr, 2'b00});
                        cmd_read_q  <= (req_op == DMI_OP_READ);
                        cmd_wdata_q <= req_data;
                        resp_data_q <= '0;
                        case (req_op)
                            DMI_OP_READ, DMI_OP_WRITE: state_q <= ST_CMD;
                            DMI_OP_NOP: begin
                                resp_code_q <= DMI_RESP_OK;
                                state_q     <= ST_RESP;
                            end
                            default: begin
                                resp_code_q <= DMI_RESP_ERR;
                                state_q     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_CMD: begin
                    if (icb_cmd_ready) begin
                        state_q <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (icb_rsp_valid) begin
                        resp_data_q <= cmd_read_q ? icb_rsp_rdata : '0;
                        resp_code_q <= icb_rsp_err ? DMI_RESP_ERR : DMI_RESP_OK;
                        // Saturating error counter
                        if (icb_rsp_err && (err_cnt_q != 8'hFF)) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (dtm_resp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register only
    assign dtm_req_ready  = (state_q == ST_IDLE) && !rst;
    assign icb_cmd_valid  = (state_q == ST_CMD);
    assign icb_rsp_ready  = (state_q == ST_RSP);
    assign dtm_resp_valid = (state_q == ST_RESP);
    assign dmi_active     = (state_q != ST_IDLE);

    assign icb_cmd_addr   = cmd_addr_q;
    assign icb_cmd_read   = cmd_read_q;
    assign icb_cmd_wdata  = cmd_wdata_q;
    assign icb_cmd_wmask  = 4'hF;
    assign dtm_resp_bits  = {resp_data_q, resp_code_q};
    assign icb_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_debug_bus2icb.sv
// Directed self-checking bench for debug_bus2icb.
module tb_debug_bus2icb;

    logic        clk;
    logic        rst;
    logic        dtm_req_valid;
    logic        dtm_req_ready;
    logic [40:0] dtm_req_bits;
    logic        dtm_resp_valid;
    logic        dtm_resp_ready;
    logic [33:0] dtm_resp_bits;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        dmi_active;
    logic [7:0]  icb_err_cnt;

    int n_cmp;
    int n_fail;

    debug_bus2icb #(
        .ICB_BASE_ADDR(32'h1000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dtm_req_valid  (dtm_req_valid),
        .dtm_req_ready  (dtm_req_ready),
        .dtm_req_bits   (dtm_req_bits),
        .dtm_resp_valid (dtm_resp_valid),
        .dtm_resp_ready (dtm_resp_ready),
        .dtm_resp_bits  (dtm_resp_bits),
        .icb_cmd_valid  (icb_cmd_valid),
        .icb_cmd_ready  (icb_cmd_ready),
        .icb_cmd_addr   (icb_cmd_addr),
        .icb_cmd_read   (icb_cmd_read),
        .icb_cmd_wdata  (icb_cmd_wdata),
        .icb_cmd_wmask  (icb_cmd_wmask),
        .icb_rsp_valid  (icb_rsp_valid),
        .icb_rsp_ready  (icb_rsp_ready),
        .icb_rsp_rdata  (icb_rsp_rdata),
        .icb_rsp_err    (icb_rsp_err),
        .dmi_active     (dmi_active),
        .icb_err_cnt    (icb_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one DMI request and services the ICB side; latency counts cycles
    // from the request handshake to dtm_resp_valid (-1 on timeout).
    task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           input int cmd_wait, input logic [31:0] rdata, input logic err,
                           output logic [33:0] resp, output int lat, output logic saw_cmd,
                           output logic [31:0] c_addr, output logic c_read,
                           output logic [31:0] c_wdata, output logic [3:0] c_wmask,
                           output logic stable);
        int cyc;
        int cmd_cnt;
        resp = '0; lat = -1; saw_cmd = 1'b0; stable = 1'b1;
        c_addr = '0; c_read = 1'b0; c_wdata = '0; c_wmask = '0;
        cmd_cnt = 0;
        dtm_req_bits  = {addr, data, op};
        dtm_req_valid = 1'b1;
        for (int i = 0; i < 50 && !dtm_req_ready; i++) tick();
        if (!dtm_req_ready) begin
            dtm_req_valid = 1'b0;
            return;
        end
        tick();
        dtm_req_valid = 1'b0;
        cyc = 1;
        while (cyc < 100 && !dtm_resp_valid) begin
            icb_cmd_ready = 1'b0;
            icb_rsp_valid = 1'b0;
            icb_rsp_rdata = '0;
            icb_rsp_err   = 1'b0;
            if (icb_cmd_valid) begin
                if (!saw_cmd) begin
                    c_addr = icb_cmd_addr; c_read = icb_cmd_read;
                    c_wdata = icb_cmd_wdata; c_wmask = icb_cmd_wmask;
                end else if (c_addr !== icb_cmd_addr || c_read !== icb_cmd_read ||
                             c_wdata !== icb_cmd_wdata || c_wmask !== icb_cmd_wmask) begin
                    stable = 1'b0;
                end
                saw_cmd = 1'b1;
                if (cmd_cnt == cmd_wait) icb_cmd_ready = 1'b1;
                cmd_cnt++;
            end
            if (icb_rsp_ready) begin
                icb_rsp_valid = 1'b1;
                icb_rsp_rdata = rdata;
                icb_rsp_err   = err;
            end
            tick();
            cyc++;
        end
        icb_cmd_ready = 1'b0;
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
        if (dtm_resp_valid) begin
            lat  = cyc;
            resp = dtm_resp_bits;
            dtm_resp_ready = 1'b1;
            tick();
            dtm_resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (dtm_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", dtm_req_ready); end
        n_cmp++; if (icb_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid got %b want 0", icb_cmd_valid); end
        n_cmp++; if (dtm_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", dtm_resp_valid); end
        n_cmp++; if (icb_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_ready got %b want 0", icb_rsp_ready); end
        n_cmp++; if (dmi_active !== 1'b0) begin n_fail++; $display("FAIL rst_active got %b want 0", dmi_active); end
        n_cmp++; if (icb_err_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_err_cnt got %h want 00", icb_err_cnt); end
        n_cmp++; if (dtm_resp_bits !== 34'h0) begin n_fail++; $display("FAIL rst_resp_bits got %h want 0", dtm_resp_bits); end
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (dtm_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready got %b want 1", dtm_req_ready); end
    endtask

    task automatic test_read();
        logic [33:0] resp; int lat; logic saw; logic [31:0] ca; logic cr; logic [31:0] cw; logic [3:0] cm; logic st;
        run_txn(2'b01, 7'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, resp, lat, saw, ca, cr, cw, cm, st);
        n_cmp++; if (ca !== 32'h1000_0040) begin n_fail++; $display("FAIL read_addr got %h want 10000040", ca); end
        n_cmp++; if (cr !== 1'b1) begin n_fail++; $display("FAIL read_flag got %b want 1", cr); end
        n_cmp++; if (resp !== {32'hDEAD_BEEF, 2'b00}) begin n_fail++; $display("FAIL read_resp got %h want %h", resp, {32'hDEAD_BEEF, 2'b00}); end
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL read_latency got %0d want 3", lat); end
        n_cmp++; if (dtm_req_ready !== 1'b1) begin n_fail++; $display("FAIL read_ready_after got %b want 1", dtm_req_ready); end
    endtask

    task automatic test_write_wait();
        logic [33:0] resp; int lat; logic saw; logic [31:0] ca; logic cr; logic [31:0] cw; logic [3:0] cm; logic st;
        run_txn(2'b10, 7'h7F, 32'h1234_5678, 4, 32'hFFFF_FFFF, 1'b0, resp, lat, saw, ca, cr, cw, cm, st);
        n_cmp++; if (ca !== 32'h1000_01FC) begin n_fail++; $display("FAIL write_addr got %h want 100001fc", ca); end
        n_cmp++; if (cr !== 1'b0) begin n_fail++; $display("FAIL write_flag got %b want 0", cr); end
        n_cmp++; if (cw !== 32'h1234_5678) begin n_fail++; $display("FAIL write_wdata got %h want 12345678", cw); end
        n_cmp++; if (cm !== 4'hF) begin n_fail++; $display("FAIL write_wmask got %h want f", cm); end
        n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL write_cmd_stable got %b want 1", st); end
        n_cmp++; if (resp !== 34'h0) begin n_fail++; $display("FAIL write_resp got %h want 0", resp); end
        n_cmp++; if (lat != 7) begin n_fail++; $display("FAIL write_latency got %0d want 7", lat); end
    endtask

    task automatic test_nop_reserved();
        logic [33:0] resp; int lat; logic saw; logic [31:0] ca; logic cr; logic [31:0] cw; logic [3:0] cm; logic st;
        run_txn(2'b00, 7'h05, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, resp, lat, saw, ca, cr, cw, cm, st);
        n_cmp++; if (resp !== 34'h0) begin n_fail++; $display("FAIL nop_resp got %h want 0", resp); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL nop_latency got %0d want 1", lat); end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL nop_icb_cmd got %b want 0", saw); end
        run_txn(2'b11, 7'h06, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, resp, lat, saw, ca, cr, cw, cm, st);
        n_cmp++; if (resp !== 34'h2) begin n_fail++; $display("FAIL rsvd_resp got %h want 2", resp); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL rsvd_latency got %0d want 1", lat); end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rsvd_icb_cmd got %b want 0", saw); end
    endtask

    task automatic test_back_to_back();
        dtm_req_bits  = {7'h01, 32'h0, 2'b00};
        dtm_req_valid = 1'b1;
        tick();
        // Second request (reserved op) pending while the first response is stalled
        dtm_req_bits = {7'h02, 32'h0, 2'b11};
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (dtm_resp_valid !== 1'b1 || dtm_resp_bits !== 34'h0) begin
                n_fail++; $display("FAIL b2b_hold_resp cyc %0d got v=%b bits=%h want v=1 bits=0", i, dtm_resp_valid, dtm_resp_bits);
            end
            n_cmp++; if (dtm_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_ready cyc %0d got %b want 0", i, dtm_req_ready); end
            tick();
        end
        dtm_resp_ready = 1'b1;
        tick();
        dtm_resp_ready = 1'b0;
        n_cmp++; if (dtm_req_ready !== 1'b1 || dtm_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_return got ready=%b rv=%b want 1 0", dtm_req_ready, dtm_resp_valid);
        end
        tick();
        dtm_req_valid = 1'b0;
        n_cmp++; if (dtm_resp_valid !== 1'b1 || dtm_resp_bits !== 34'h2) begin
            n_fail++; $display("FAIL b2b_second_resp got v=%b bits=%h want v=1 bits=2", dtm_resp_valid, dtm_resp_bits);
        end
        dtm_resp_ready = 1'b1;
        tick();
        dtm_resp_ready = 1'b0;
    endtask

    task automatic test_err_sat();
        logic [33:0] resp; int lat; logic saw; logic [31:0] ca; logic cr; logic [31:0] cw; logic [3:0] cm; logic st;
        logic [33:0] exp_resp; logic [31:0] rd; logic [7:0] exp_cnt;
        for (int i = 0; i < 300; i++) begin
            rd = 32'hC000_0000 + 32'(i);
            if (i % 2 == 0) begin
                run_txn(2'b01, 7'(i), 32'h0, 0, rd, 1'b1, resp, lat, saw, ca, cr, cw, cm, st);
                exp_resp = {rd, 2'b10};
            end else begin
                run_txn(2'b10, 7'(i), 32'h5555_0000, 0, rd, 1'b1, resp, lat, saw, ca, cr, cw, cm, st);
                exp_resp = {32'h0, 2'b10};
            end
            exp_cnt = (i >= 254) ? 8'hFF : 8'(i + 1);
            n_cmp++; if (resp !== exp_resp) begin n_fail++; $display("FAIL err_resp txn %0d got %h want %h", i, resp, exp_resp); end
            n_cmp++; if (icb_err_cnt !== exp_cnt) begin n_fail++; $display("FAIL err_cnt txn %0d got %h want %h", i, icb_err_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        dtm_req_bits  = {7'h22, 32'h0, 2'b01};
        dtm_req_valid = 1'b1;
        tick();
        dtm_req_valid = 1'b0;
        icb_cmd_ready = 1'b1;
        tick();
        icb_cmd_ready = 1'b0;
        n_cmp++; if (icb_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_rsp got %b want 1", icb_rsp_ready); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (icb_rsp_ready !== 1'b0 || icb_cmd_valid !== 1'b0 || dtm_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_valids got rr=%b cv=%b rv=%b want 0 0 0", icb_rsp_ready, icb_cmd_valid, dtm_resp_valid);
        end
        n_cmp++; if (dmi_active !== 1'b0) begin n_fail++; $display("FAIL mid_active got %b want 0", dmi_active); end
        n_cmp++; if (dtm_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_req_ready got %b want 0", dtm_req_ready); end
        n_cmp++; if (icb_err_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_err_cnt got %h want 00", icb_err_cnt); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (dtm_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got %b want 1", dtm_req_ready); end
        n_cmp++; if (icb_err_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_release_cnt got %h want 00", icb_err_cnt); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        dtm_req_valid = 1'b0; dtm_req_bits = '0; dtm_resp_ready = 1'b0;
        icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_rdata = '0; icb_rsp_err = 1'b0;
        test_reset();
        test_read();
        test_write_wait();
        test_nop_reserved();
        test_back_to_back();
        test_err_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
